// File: rtl/tone_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tone_cmd_fifo
//
// Fabric-side endpoint of the Nios tone-command PIO link. Software strobes
// 32-bit tone words in on ld_fifo. They are buffered in a FIFO and played out
// in order. Each word sounds for a programmed number of audio samples, and its
// phase increment is presented to the synthesizer oscillator while it plays.
//
// Tone word format: [31:16] phase increment, [15:0] duration in samples.
//
// Ports
//   clk_clk        in   main system clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   ld_fifo        in   PIO load strobe (level); each rising edge pushes one word
//   tone[TW-1:0]   in   PIO tone word, captured on the detected ld_fifo edge
//   stop           in   synchronous flush of FIFO, player and overflow flag
//   sample_tick    in   one-cycle pulse per audio sample (spacing >= 4 clocks)
//   fifo_full      out  FIFO holds DEPTH words
//   run            out  a tone is playing or words are still queued
//   phase_inc[15:0] out oscillator phase increment, 0 = silence
//   gate           out  a tone is sounding (player in PLAY)
//   overflow       out  sticky: a push arrived while the FIFO was full
//
// Push handshake: there is no ready signal back to software. A push is
// accepted on the cycle the ld_fifo rising edge is detected, if and only if
// the registered count is below DEPTH and stop is low. A push seen while full
// is dropped and flagged on overflow. A push seen together with stop is
// dropped silently. Software polls fifo_full before strobing.
// -----------------------------------------------------------------------------
module tone_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int TW    = 32
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          ld_fifo,
    input  logic [TW-1:0] tone,
    input  logic          stop,
    input  logic          sample_tick,
    output logic          fifo_full,
    output logic          run,
    output logic [15:0]   phase_inc,
    output logic          gate,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    // DEPTH is a power of two, so the full count is just the top count bit.
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;

    logic            ld_q;
    logic [TW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [15:0]     remain;

    logic            push_req;
    logic            full;
    logic            push;
    logic            ovf_set;
    logic            pop;
    logic [TW-1:0]   head;
    logic [15:0]     head_phase;
    logic [15:0]     head_dur;

    assign push_req   = ld_fifo & ~ld_q;
    // Full comes from the registered count, so a pop on this same edge does not
    // make room for the incoming word.
    assign full       = (count == FULL_CNT);
    assign push       = push_req & ~full & ~stop;
    assign ovf_set    = push_req & full & ~stop;

    assign head       = mem[rd_ptr];
    assign head_phase = head[31:16];
    assign head_dur   = head[15:0];

    // -------------------------------------------------------------------------
    // Player FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Player FSM: next state and pop decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    // A zero-duration word is consumed but never sounds.
                    if (head_dur != 16'd0) begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (sample_tick && (remain == 16'd1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by count)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= tone;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count, overflow flag, tone registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ld_q      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            phase_inc <= 16'd0;
            remain    <= 16'd0;
        end else begin
            // Edge detector keeps tracking through stop so a held level
            // never turns into a late push afterwards.
            ld_q <= ld_fifo;
            if (stop) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                phase_inc <= 16'd0;
                remain    <= 16'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (ovf_set) begin
                    overflow <= 1'b1;
                end

                if (state == IDLE) begin
                    if (count == '0) begin
                        phase_inc <= 16'd0;
                    end else if (pop && (head_dur != 16'd0)) begin
                        phase_inc <= head_phase;
                        remain    <= head_dur;
                    end
                end else if (sample_tick) begin
                    // phase_inc is held through the last tick so the tone
                    // never drops out between back-to-back words.
                    remain <= remain - 16'd1;
                end
            end
        end
    end

    assign fifo_full = full;
    assign gate      = (state == PLAY);
    assign run       = (state == PLAY) | (count != '0);

endmodule

// File: tb/tb_tone_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tb_tone_cmd_fifo
//
// Directed bench for tone_cmd_fifo. Inputs are driven and outputs sampled 1 ns
// after each rising clock edge, so every check reflects the state produced by
// the edge just taken.
// -----------------------------------------------------------------------------
module tb_tone_cmd_fifo;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_fifo = 1'b0;
    logic [31:0] tone = 32'h0;
    logic        stop = 1'b0;
    logic        sample_tick = 1'b0;

    logic        fifo_full;
    logic        run;
    logic [15:0] phase_inc;
    logic        gate;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tone_cmd_fifo #(
        .DEPTH (16),
        .TW    (32)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .ld_fifo       (ld_fifo),
        .tone          (tone),
        .stop          (stop),
        .sample_tick   (sample_tick),
        .fifo_full     (fifo_full),
        .run           (run),
        .phase_inc     (phase_inc),
        .gate          (gate),
        .overflow      (overflow)
    );

    // ---------------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Rising edge on ld_fifo at the first edge, low again for the second.
    task automatic push_word(input logic [31:0] w);
        tone    = w;
        ld_fifo = 1'b1;
        step();
        ld_fifo = 1'b0;
        step();
    endtask

    task automatic tick_pulse();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        wait_clks(3);
        check("rst_phase", 32'(phase_inc), 32'h0);
        check("rst_gate",  32'(gate),      32'h0);
        check("rst_full",  32'(fifo_full), 32'h0);
        check("rst_run",   32'(run),       32'h0);
        check("rst_ovf",   32'(overflow),  32'h0);
        rst_n = 1'b1;
        step();

        // Single tone 0x1234 for 3 ticks
        tone    = 32'h1234_0003;
        ld_fifo = 1'b1;
        step();                                   // edge E: push
        check("t1_run_E",   32'(run),       32'h1);
        check("t1_gate_E",  32'(gate),      32'h0);
        check("t1_phase_E", 32'(phase_inc), 32'h0);
        ld_fifo = 1'b0;
        step();                                   // edge E+1: pop
        check("t1_phase",   32'(phase_inc), 32'h1234);
        check("t1_gate",    32'(gate),      32'h1);
        wait_clks(3);
        tick_pulse();
        check("t1_tick1_gate", 32'(gate), 32'h1);
        wait_clks(3);
        tick_pulse();
        check("t1_tick2_gate", 32'(gate), 32'h1);
        wait_clks(3);
        tick_pulse();
        check("t1_tick3_gate",  32'(gate),      32'h0);
        check("t1_tick3_phase", 32'(phase_inc), 32'h1234);
        check("t1_tick3_run",   32'(run),       32'h0);
        step();
        check("t1_silence", 32'(phase_inc), 32'h0);
        wait_clks(2);

        // Fill with ticks stalled. Word 0 is popped straight into PLAY, so the
        // queue holds 15 after 16 pushes and reaches 16 on the 17th.
        for (int i = 0; i < 16; i++) push_word({16'(32'h1000 + i), 16'h0001});
        check("fill_playing", 32'(phase_inc), 32'h1000);
        check("fill_16_full", 32'(fifo_full), 32'h0);
        push_word({16'h1010, 16'h0001});
        check("fill_17_full", 32'(fifo_full), 32'h1);
        check("fill_17_ovf",  32'(overflow),  32'h0);
        push_word({16'h1011, 16'h0001});
        check("fill_18_ovf",  32'(overflow),  32'h1);
        check("fill_18_full", 32'(fifo_full), 32'h1);
        wait_clks(2);
        // Play-out in push order; word 0x1010 sits in slot 0 after the wrap.
        for (int i = 1; i <= 16; i++) begin
            tick_pulse();
            check("order_gap", 32'(gate), 32'h0);
            step();
            check("order_phase", 32'(phase_inc), 32'(32'h1000 + i));
            wait_clks(2);
        end
        tick_pulse();
        check("drain_gate", 32'(gate),      32'h0);
        check("drain_run",  32'(run),       32'h0);
        check("drain_full", 32'(fifo_full), 32'h0);
        step();
        check("drain_phase", 32'(phase_inc), 32'h0);
        check("drain_ovf",   32'(overflow),  32'h1);
        wait_clks(2);

        // Zero-duration words are skipped
        push_word(32'hAAAA_0000);
        check("zd_gate",  32'(gate),      32'h0);
        check("zd_phase", 32'(phase_inc), 32'h0);
        check("zd_run",   32'(run),       32'h0);
        push_word(32'h5555_0002);
        check("zd_next_phase", 32'(phase_inc), 32'h5555);
        check("zd_next_gate",  32'(gate),      32'h1);
        tick_pulse();
        check("zd_tick1_gate", 32'(gate), 32'h1);
        push_word(32'hAAAA_0000);
        push_word(32'h7777_0001);
        tick_pulse();
        check("zd_tick2_gate",  32'(gate),      32'h0);
        check("zd_tick2_phase", 32'(phase_inc), 32'h5555);
        step();
        check("zd_skip_phase", 32'(phase_inc), 32'h5555);
        check("zd_skip_gate",  32'(gate),      32'h0);
        check("zd_skip_run",   32'(run),       32'h1);
        step();
        check("zd_7777_phase", 32'(phase_inc), 32'h7777);
        check("zd_7777_gate",  32'(gate),      32'h1);
        wait_clks(1);
        tick_pulse();
        check("zd_end_gate", 32'(gate), 32'h0);
        check("zd_end_run",  32'(run),  32'h0);
        step();
        check("zd_end_phase", 32'(phase_inc), 32'h0);
        wait_clks(2);

        // ld_fifo held high for 20 clocks pushes once
        tone    = 32'h4444_0001;
        ld_fifo = 1'b1;
        wait_clks(20);
        check("hold_phase", 32'(phase_inc), 32'h4444);
        check("hold_gate",  32'(gate),      32'h1);
        ld_fifo = 1'b0;
        step();
        tick_pulse();
        check("hold_end_gate", 32'(gate), 32'h0);
        check("hold_one_push", 32'(run),  32'h0);
        step();
        check("hold_end_phase", 32'(phase_inc), 32'h0);
        wait_clks(2);

        // stop mid-play with 5 queued, plus a concurrent push
        push_word(32'h6000_0004);
        for (int i = 0; i < 5; i++) push_word({16'(32'h6100 + i), 16'h0001});
        check("stop_pre_run",   32'(run),       32'h1);
        check("stop_pre_phase", 32'(phase_inc), 32'h6000);
        check("stop_pre_ovf",   32'(overflow),  32'h1);
        stop    = 1'b1;
        tone    = 32'h9999_0001;
        ld_fifo = 1'b1;
        step();
        stop    = 1'b0;
        ld_fifo = 1'b0;
        check("stop_run",   32'(run),       32'h0);
        check("stop_gate",  32'(gate),      32'h0);
        check("stop_phase", 32'(phase_inc), 32'h0);
        check("stop_ovf",   32'(overflow),  32'h0);
        check("stop_full",  32'(fifo_full), 32'h0);
        step();
        check("stop_push_lost_run",  32'(run),  32'h0);
        check("stop_push_lost_gate", 32'(gate), 32'h0);
        wait_clks(2);

        // Push coincident with pop of the last entry
        push_word(32'h7100_0001);
        push_word(32'h7200_0002);
        tick_pulse();
        check("pp_a_end", 32'(gate), 32'h0);
        tone    = 32'h7300_0001;
        ld_fifo = 1'b1;
        step();
        ld_fifo = 1'b0;
        check("pp_b_phase", 32'(phase_inc), 32'h7200);
        check("pp_b_gate",  32'(gate),      32'h1);
        check("pp_b_run",   32'(run),       32'h1);
        wait_clks(2);
        tick_pulse();
        check("pp_b_tick1", 32'(gate), 32'h1);
        wait_clks(3);
        tick_pulse();
        check("pp_b_end_gate", 32'(gate), 32'h0);
        check("pp_c_queued",   32'(run),  32'h1);
        step();
        check("pp_c_phase", 32'(phase_inc), 32'h7300);
        check("pp_c_gate",  32'(gate),      32'h1);

        // Asynchronous reset mid-tone
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_phase", 32'(phase_inc), 32'h0);
        check("arst_gate",  32'(gate),      32'h0);
        check("arst_run",   32'(run),       32'h0);
        check("arst_full",  32'(fifo_full), 32'h0);
        check("arst_ovf",   32'(overflow),  32'h0);
        step();
        rst_n = 1'b1;
        wait_clks(2);
        check("post_rst_run",   32'(run),       32'h0);
        check("post_rst_phase", 32'(phase_inc), 32'h0);

        // ---------------------------------------------------------------- report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
